// File: rtl/ann_pkg.sv
// rtl/ann_pkg.sv - shared constants, FSM encoding and flat-bus index helpers for the ANN engines
package ann_pkg;

  localparam int N_OUT   = 10;
  localparam int N_HID   = 30;
  localparam int DATA_W  = 8;
  localparam int ACC_W   = 24;
  localparam int N_IDX_W = $clog2(N_OUT);
  localparam int J_IDX_W = $clog2(N_HID);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC,
    ST_STORE,
    ST_DONE
  } ann_state_e;

  // Bit offsets into the flattened weight / bias / activation / score buses.
  function automatic int w_base(input int n, input int j);
    return (n * N_HID + j) * DATA_W;
  endfunction

  function automatic int b_base(input int n);
    return n * DATA_W;
  endfunction

  function automatic int a_base(input int j);
    return j * DATA_W;
  endfunction

  function automatic int s_base(input int n);
    return n * ACC_W;
  endfunction

endpackage

// File: rtl/output_mac_unit.sv
// rtl/output_mac_unit.sv - signed DATA_W x DATA_W multiply with ACC_W accumulator
module output_mac_unit
  import ann_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic                     en,
  input  logic signed [ACC_W-1:0]  load_val,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;

  assign prod = a * b;

  // Accumulator wraps silently; default sizes cannot overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (load) begin
      acc <= load_val;
    end else if (en) begin
      acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end
  end

endmodule

// File: rtl/output_layer_engine.sv
// rtl/output_layer_engine.sv - output-layer scores via one MAC per cycle, plus argmax digit
module output_layer_engine
  import ann_pkg::*;
#(
  parameter int BIAS_SHIFT = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [DATA_W*N_HID-1:0]         act_in,
  input  logic [DATA_W*N_OUT*N_HID-1:0]   weights_HL,
  input  logic [DATA_W*N_OUT-1:0]         biases_HL,
  output logic                            ready,
  output logic                            busy,
  output logic                            done,
  output logic [ACC_W*N_OUT-1:0]          scores,
  output logic [3:0]                      digit
);

  localparam logic [N_IDX_W-1:0] N_LAST = N_IDX_W'(N_OUT - 1);
  localparam logic [J_IDX_W-1:0] J_LAST = J_IDX_W'(N_HID - 1);

  ann_state_e state, state_nx;

  logic [N_IDX_W-1:0]       n;
  logic [J_IDX_W-1:0]       j;
  logic [DATA_W*N_HID-1:0]  act_q;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  max_q;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [DATA_W-1:0] w_op, a_op, b_op;
  logic                     mac_load, mac_en;

  assign w_op     = weights_HL[w_base(int'(n), int'(j)) +: DATA_W];
  assign a_op     = act_q[a_base(int'(j)) +: DATA_W];
  assign b_op     = biases_HL[b_base(int'(n)) +: DATA_W];
  assign bias_ext = {{(ACC_W-DATA_W){b_op[DATA_W-1]}}, b_op} << BIAS_SHIFT;

  output_mac_unit u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (mac_load),
    .en       (mac_en),
    .load_val (bias_ext),
    .a        (w_op),
    .b        (a_op),
    .acc      (acc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    mac_load = 1'b0;
    mac_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        busy     = 1'b1;
        mac_load = 1'b1;
        state_nx = ST_MAC;
      end
      ST_MAC: begin
        busy   = 1'b1;
        mac_en = 1'b1;
        if (j == J_LAST) state_nx = ST_STORE;
      end
      ST_STORE: begin
        busy     = 1'b1;
        state_nx = (n == N_LAST) ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n      <= '0;
      j      <= '0;
      act_q  <= '0;
      max_q  <= '0;
      scores <= '0;
      digit  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            act_q <= act_in;
            n     <= '0;
            j     <= '0;
          end
        end
        ST_LOAD: j <= '0;
        ST_MAC:  j <= j + J_IDX_W'(1);
        ST_STORE: begin
          scores[s_base(int'(n)) +: ACC_W] <= acc;
          // Strict compare so ties keep the lower index.
          if (n == '0 || acc > max_q) begin
            max_q <= acc;
            digit <= 4'(n);
          end
          if (n != N_LAST) n <= n + N_IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_output_layer_engine.sv
// tb/tb_output_layer_engine.sv - scoreboard bench for output_layer_engine
module tb_output_layer_engine;
  import ann_pkg::*;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          start;
  logic [DATA_W*N_HID-1:0]       act_in;
  logic [DATA_W*N_OUT*N_HID-1:0] weights_HL;
  logic [DATA_W*N_OUT-1:0]       biases_HL;
  logic                          ready, busy, done;
  logic [ACC_W*N_OUT-1:0]        scores;
  logic [3:0]                    digit;

  output_layer_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .act_in     (act_in),
    .weights_HL (weights_HL),
    .biases_HL  (biases_HL),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .scores     (scores),
    .digit      (digit)
  );

  always #5 clk = ~clk;

  int w [N_OUT][N_HID];
  int b [N_OUT];
  int a [N_HID];
  int exp_sc_q [$];
  int exp_dg_q [$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int start_cyc = 0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_and_push();
    int s, best, dg;
    best = 0;
    dg = 0;
    for (int i = 0; i < N_OUT; i++) begin
      biases_HL[i*DATA_W +: DATA_W] = 8'(b[i]);
      for (int k = 0; k < N_HID; k++)
        weights_HL[(i*N_HID+k)*DATA_W +: DATA_W] = 8'(w[i][k]);
    end
    for (int k = 0; k < N_HID; k++) act_in[k*DATA_W +: DATA_W] = 8'(a[k]);
    for (int i = 0; i < N_OUT; i++) begin
      s = b[i];
      for (int k = 0; k < N_HID; k++) s += w[i][k] * a[k];
      exp_sc_q.push_back(s);
      if (i == 0 || s > best) begin
        best = s;
        dg = i;
      end
    end
    exp_dg_q.push_back(dg);
  endtask

  task automatic issue_start();
    apply_and_push();
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int k = 0; k < bound && done !== 1'b1; k++) tick();
    check("done_seen", int'(done === 1'b1), 1);
  endtask

  task automatic compare_out();
    if (exp_dg_q.size() == 0) begin
      check("sb_nonempty", 0, 1);
      return;
    end
    for (int i = 0; i < N_OUT; i++)
      check($sformatf("score%0d", i), int'($signed(scores[i*ACC_W +: ACC_W])), exp_sc_q.pop_front());
    check("digit", int'(digit), exp_dg_q.pop_front());
  endtask

  task automatic run_once(input string tag);
    int d0;
    d0 = done_cnt;
    issue_start();
    wait_done(400);
    check({tag, "_latency"}, cyc - start_cyc, 321);
    compare_out();
    tick();
    check({tag, "_ready_after"}, int'(ready), 1);
    check({tag, "_one_done"}, done_cnt - d0, 1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < N_OUT; i++) begin
      b[i] = int'($urandom_range(0, 255)) - 128;
      for (int k = 0; k < N_HID; k++) w[i][k] = int'($urandom_range(0, 255)) - 128;
    end
    for (int k = 0; k < N_HID; k++) a[k] = int'($urandom_range(0, 255)) - 128;
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    start = 1'b0;
    act_in = '0;
    weights_HL = '0;
    biases_HL = '0;
    tick();
    tick();
    check("rst_ready", int'(ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_scores_nz", int'(|scores), 0);
    check("rst_digit", int'(digit), 0);
    rst_n = 1'b1;
    tick();

    // Zero weights, biases 0..9
    for (int i = 0; i < N_OUT; i++) begin
      b[i] = i;
      for (int k = 0; k < N_HID; k++) w[i][k] = 0;
    end
    for (int k = 0; k < N_HID; k++) a[k] = int'($urandom_range(0, 255)) - 128;
    run_once("bias_only");

    // Neuron 3 weights all 1, activations all 2
    for (int i = 0; i < N_OUT; i++) begin
      b[i] = 0;
      for (int k = 0; k < N_HID; k++) w[i][k] = (i == 3) ? 1 : 0;
    end
    for (int k = 0; k < N_HID; k++) a[k] = 2;
    run_once("neuron3");

    // Extremes: every score -487808, tie resolves to digit 0
    for (int i = 0; i < N_OUT; i++) begin
      b[i] = -128;
      for (int k = 0; k < N_HID; k++) w[i][k] = -128;
    end
    for (int k = 0; k < N_HID; k++) a[k] = 127;
    run_once("extremes");
    check("extreme_value", int'($signed(scores[0 +: ACC_W])), -487808);

    // Restarts during a run and in DONE are ignored
    fill_random();
    d0 = done_cnt;
    issue_start();
    while (cyc - start_cyc < 321 && done !== 1'b1) begin
      if (cyc - start_cyc == 50) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check("restart_latency", cyc - start_cyc, 321);
    check("restart_done", int'(done), 1);
    compare_out();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_ready", int'(ready), 1);
    check("restart_busy", int'(busy), 0);
    check("restart_one_done", done_cnt - d0, 1);
    tick();
    fill_random();
    d0 = start_cyc;
    issue_start();
    check("second_start_cycle", start_cyc - d0, 323);
    wait_done(400);
    check("second_done_cycle", cyc - d0, 644);
    compare_out();
    tick();

    // Reset mid-run abandons the computation
    fill_random();
    issue_start();
    while (cyc - start_cyc < 150) tick();
    rst_n = 1'b0;
    tick();
    check("midrst_ready", int'(ready), 1);
    check("midrst_busy", int'(busy), 0);
    check("midrst_scores_nz", int'(|scores), 0);
    check("midrst_digit", int'(digit), 0);
    rst_n = 1'b1;
    exp_sc_q.delete();
    exp_dg_q.delete();
    d0 = done_cnt;
    repeat (400) tick();
    check("midrst_no_done", done_cnt - d0, 0);
    fill_random();
    run_once("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_layer_engine.md
Name: output_layer_engine

Overview:
- Consumer of the output-layer parameter block: reads its flattened weight bus (10x30, int8) and bias bus (10, int8) and computes the 10 digit scores from the 30 hidden-layer activations.
- Uses one signed MAC per cycle, sequenced by an FSM.
- After the last score it produces the argmax digit and a one-cycle done pulse.
- Sits between the hidden-layer engine and the digit display/readout logic.

Parameters:
- N_OUT, 10, number of output neurons (digits).
- N_HID, 30, number of hidden activations per neuron.
- DATA_W, 8, width of weights, biases and activations (signed two's complement).
- ACC_W, 24, accumulator and score width (signed).
- BIAS_SHIFT, 0, left shift applied to the sign-extended bias so it aligns with the product scale.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request a computation; sampled only when ready=1.
- act_in  in  DATA_W*N_HID  hidden activations; activation j at [j*8 +: 8]; latched on an accepted start.
- weights_HL  in  DATA_W*N_OUT*N_HID  weight for neuron i, input j at [(i*30+j)*8 +: 8]; must be held stable while busy.
- biases_HL  in  DATA_W*N_OUT  bias for neuron i at [i*8 +: 8]; must be held stable while busy.
- ready  out  1  high in IDLE.
- busy  out  1  high in LOAD, MAC and STORE.
- done  out  1  one-cycle pulse when all scores and the digit are valid.
- scores  out  ACC_W*N_OUT  score of neuron i at [i*24 +: 24]; held until the next accepted start.
- digit  out  4  argmax index 0..9; held with scores.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; ready=1, busy=0, done=0.
  - scores=0, digit=0; internal counters, accumulator and running max cleared.
  - Reset mid-operation abandons the computation immediately with the same values.
- IDLE: on start=1, latch act_in, clear n=0, j=0, and go to LOAD.
- LOAD (1 cycle): acc = sign-extended bias[n] << BIAS_SHIFT; j=0; go to MAC.
- MAC (N_HID cycles): acc += sext(w[n][j]) * sext(act[j]), a 16-bit signed product sign-extended to ACC_W. j increments each cycle; after j=N_HID-1, go to STORE.
- STORE (1 cycle):
  - scores[n] = acc.
  - If n==0, or acc > max (strict), then max=acc and digit=n. Ties keep the lower index.
  - If n<N_OUT-1: n++, go to LOAD.
  - Otherwise go to DONE.
- DONE (1 cycle): done=1; go to IDLE. ready returns the following cycle.
- Latency: start accepted at cycle 0 → done=1 at cycle 1 + N_OUT*(N_HID+2) = 321 (defaults).
- start while busy or in DONE is ignored; no queueing.
- scores/digit are updated per neuron during the run; they are guaranteed consistent only from done onward.
- No overflow at defaults: worst case 30*16384 + 128 < 2^23. No saturation logic is required; the accumulator wraps if parameters are changed.

Decomposition:
- Shared package (ann_pkg) holds:
  - N_OUT, N_HID, DATA_W, ACC_W constants.
  - FSM state encoding: IDLE, LOAD, MAC, STORE, DONE.
  - Index helper functions for the flattened buses, shared with the parameter block.
- One natural sub-module: output_mac_unit.
  - Inputs: signed DATA_W x DATA_W multiply, load/enable controls.
  - Contains the ACC_W accumulator.
  - The top level keeps the FSM, counters, operand muxing and argmax.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles → ready=1, busy=0, done=0, scores=0, digit=0.
- All zero weights; biases = {0,1,2,...,9}; act=anything; start → done at cycle 321, scores[i]=i, digit=9.
- Neuron 3 weights all 1, others all 0; biases 0; act all 2 → scores[3]=60, others 0, digit=3.
- Extremes: weights all -128, act all 127, bias -128 → every score = -487808; tie → digit=0.
- start pulsed again at cycles 50 and 321 during the first run → ignored; exactly one done. Then a new start at 323 is accepted and done follows at 644.
- Reset asserted at cycle 150 mid-run → next cycle IDLE, scores=0, digit=0; no done pulse. A subsequent start yields correct results.
